// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for a 5-stage pipeline without forwarding. A destination-register
// scoreboard mirrors EX/MEM/WB; the ID/EX enable is tied high outside, so stalls are bubbles.
module pipeline_hazard_ctrl #(
    parameter bit          WB_BYPASS = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk_HAZ,
    input  logic             rst_HAZ,
    input  logic             valid_ID,
    input  logic [4:0]       rs1_addr_ID,
    input  logic             rs1_used_ID,
    input  logic [4:0]       rs2_addr_ID,
    input  logic             rs2_used_ID,
    input  logic [4:0]       rd_addr_ID,
    input  logic             RegWrite_ID,
    input  logic             redirect_EX,
    output logic             en_PC,
    output logic             en_IFID,
    output logic             NOP_IFID,
    output logic             NOP_IDEX,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic             ex_v_q, ex_v_d, mem_v_q, mem_v_d, wb_v_q, wb_v_d;
    logic [4:0]       ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             rs1_match, rs2_match, hazard, issue;

    // With WB_BYPASS the register file writes before it reads, so WB never conflicts.
    always_comb begin
        rs1_match = (ex_v_q && (ex_rd_q == rs1_addr_ID)) ||
                    (mem_v_q && (mem_rd_q == rs1_addr_ID)) ||
                    (!WB_BYPASS && wb_v_q && (wb_rd_q == rs1_addr_ID));
        rs2_match = (ex_v_q && (ex_rd_q == rs2_addr_ID)) ||
                    (mem_v_q && (mem_rd_q == rs2_addr_ID)) ||
                    (!WB_BYPASS && wb_v_q && (wb_rd_q == rs2_addr_ID));
        hazard    = valid_ID &&
                    ((rs1_used_ID && (rs1_addr_ID != 5'd0) && rs1_match) ||
                     (rs2_used_ID && (rs2_addr_ID != 5'd0) && rs2_match));
        issue     = valid_ID && !hazard && !redirect_EX;
    end

    always_comb begin
        en_PC    = 1'b1;
        en_IFID  = 1'b1;
        NOP_IFID = 1'b0;
        NOP_IDEX = 1'b0;
        if (redirect_EX) begin
            NOP_IFID = 1'b1;
            NOP_IDEX = 1'b1;
        end else if (hazard) begin
            en_PC    = 1'b0;
            en_IFID  = 1'b0;
            NOP_IDEX = 1'b1;
        end
    end

    always_comb begin
        ex_v_d   = 1'b0;
        ex_rd_d  = 5'd0;
        if (issue) begin
            ex_v_d  = RegWrite_ID && (rd_addr_ID != 5'd0);
            ex_rd_d = rd_addr_ID;
        end
        mem_v_d  = ex_v_q;
        mem_rd_d = ex_rd_q;
        wb_v_d   = mem_v_q;
        wb_rd_d  = mem_rd_q;

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hazard && !redirect_EX && (stall_cnt_q != CntMax)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (redirect_EX && (flush_cnt_q != CntMax)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_HAZ or posedge rst_HAZ) begin
        if (rst_HAZ) begin
            ex_v_q      <= 1'b0;
            ex_rd_q     <= 5'd0;
            mem_v_q     <= 1'b0;
            mem_rd_q    <= 5'd0;
            wb_v_q      <= 1'b0;
            wb_rd_q     <= 5'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_v_q      <= ex_v_d;
            ex_rd_q     <= ex_rd_d;
            mem_v_q     <= mem_v_d;
            mem_rd_q    <= mem_rd_d;
            wb_v_q      <= wb_v_d;
            wb_rd_q     <= wb_rd_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: three controllers (WB bypass, no WB bypass, 4-bit counters) share one
// instruction stream; each is checked against hand-derived per-cycle expectations.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid_id = 1'b0;
    logic [4:0] rs1 = 5'd0, rs2 = 5'd0, rd = 5'd0;
    logic       rs1_used = 1'b0, rs2_used = 1'b0, reg_write = 1'b0, redirect = 1'b0;

    logic        a_pc, a_ifid, a_nop_ifid, a_nop_idex;
    logic [15:0] a_stall, a_flush;
    logic        b_pc, b_ifid, b_nop_ifid, b_nop_idex;
    logic [15:0] b_stall, b_flush;
    logic        c_pc, c_ifid, c_nop_ifid, c_nop_idex;
    logic [3:0]  c_stall, c_flush;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.WB_BYPASS(1'b1), .CNT_W(16)) u_byp (
        .clk_HAZ(clk), .rst_HAZ(rst), .valid_ID(valid_id),
        .rs1_addr_ID(rs1), .rs1_used_ID(rs1_used), .rs2_addr_ID(rs2), .rs2_used_ID(rs2_used),
        .rd_addr_ID(rd), .RegWrite_ID(reg_write), .redirect_EX(redirect),
        .en_PC(a_pc), .en_IFID(a_ifid), .NOP_IFID(a_nop_ifid), .NOP_IDEX(a_nop_idex),
        .stall_cnt(a_stall), .flush_cnt(a_flush)
    );

    pipeline_hazard_ctrl #(.WB_BYPASS(1'b0), .CNT_W(16)) u_nobyp (
        .clk_HAZ(clk), .rst_HAZ(rst), .valid_ID(valid_id),
        .rs1_addr_ID(rs1), .rs1_used_ID(rs1_used), .rs2_addr_ID(rs2), .rs2_used_ID(rs2_used),
        .rd_addr_ID(rd), .RegWrite_ID(reg_write), .redirect_EX(redirect),
        .en_PC(b_pc), .en_IFID(b_ifid), .NOP_IFID(b_nop_ifid), .NOP_IDEX(b_nop_idex),
        .stall_cnt(b_stall), .flush_cnt(b_flush)
    );

    pipeline_hazard_ctrl #(.WB_BYPASS(1'b1), .CNT_W(4)) u_cnt4 (
        .clk_HAZ(clk), .rst_HAZ(rst), .valid_ID(valid_id),
        .rs1_addr_ID(rs1), .rs1_used_ID(rs1_used), .rs2_addr_ID(rs2), .rs2_used_ID(rs2_used),
        .rd_addr_ID(rd), .RegWrite_ID(reg_write), .redirect_EX(redirect),
        .en_PC(c_pc), .en_IFID(c_ifid), .NOP_IFID(c_nop_ifid), .NOP_IDEX(c_nop_idex),
        .stall_cnt(c_stall), .flush_cnt(c_flush)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Packs {en_PC, en_IFID, NOP_IFID, NOP_IDEX} for compact checks.
    function automatic logic [3:0] ctl_a();
        return {a_pc, a_ifid, a_nop_ifid, a_nop_idex};
    endfunction
    function automatic logic [3:0] ctl_b();
        return {b_pc, b_ifid, b_nop_ifid, b_nop_idex};
    endfunction
    function automatic logic [3:0] ctl_c();
        return {c_pc, c_ifid, c_nop_ifid, c_nop_idex};
    endfunction

    localparam logic [3:0] CtlRun   = 4'b1100;
    localparam logic [3:0] CtlStall = 4'b0001;
    localparam logic [3:0] CtlFlush = 4'b1111;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] a1, input logic u1,
                          input logic [4:0] a2, input logic u2,
                          input logic [4:0] d, input logic w);
        valid_id = v; rs1 = a1; rs1_used = u1; rs2 = a2; rs2_used = u2;
        rd = d; reg_write = w;
        #1;
    endtask

    task automatic do_reset();
        redirect = 1'b0;
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        #2;
        check_eq("rst_ctl", ctl_a(), CtlRun);
        check_eq("rst_stall", a_stall, 0);
        check_eq("rst_flush", a_flush, 0);
        do_reset();

        // Reset in the middle of a stall
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        next_cycle();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1);
        check_eq("t1_stall_c1", ctl_a(), CtlStall);
        next_cycle();
        check_eq("t1_stall_c2", ctl_a(), CtlStall);
        check_eq("t1_cnt_mid", a_stall, 1);
        rst = 1'b1;
        #1;
        check_eq("t1_rst_ctl", ctl_a(), CtlRun);
        check_eq("t1_rst_stall", a_stall, 0);
        check_eq("t1_rst_flush", a_flush, 0);
        #1;
        rst = 1'b0;
        #1;
        check_eq("t1_release_ctl", ctl_a(), CtlRun);
        next_cycle();
        // x6 producer issued on the first edge after release, so its reader must stall
        set_id(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        check_eq("t1_issued", ctl_a(), CtlStall);

        // Back-to-back dependency: 2 stalls with bypass, 3 without
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        check_eq("t2_prod_issue", ctl_a(), CtlRun);
        next_cycle();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        check_eq("t2_byp_c1", ctl_a(), CtlStall);
        check_eq("t3_nobyp_c1", ctl_b(), CtlStall);
        next_cycle();
        check_eq("t2_byp_c2", ctl_a(), CtlStall);
        check_eq("t3_nobyp_c2", ctl_b(), CtlStall);
        next_cycle();
        check_eq("t2_byp_c3", ctl_a(), CtlRun);
        check_eq("t3_nobyp_c3", ctl_b(), CtlStall);
        next_cycle();
        check_eq("t3_nobyp_c4", ctl_b(), CtlRun);
        check_eq("t2_byp_c4", ctl_a(), CtlRun);
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        next_cycle();
        check_eq("t2_stall_cnt", a_stall, 2);
        check_eq("t3_stall_cnt", b_stall, 3);
        check_eq("t2_cnt4", c_stall, 2);

        // x0 producer/reader and an unused rs2 never stall
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        next_cycle();
        set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        check_eq("t4_x0_byp", ctl_a(), CtlRun);
        check_eq("t4_x0_nobyp", ctl_b(), CtlRun);
        next_cycle();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        next_cycle();
        set_id(1'b1, 5'd0, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0);
        check_eq("t4_rs2_unused", ctl_a(), CtlRun);
        check_eq("t4_rs2_unused_nb", ctl_b(), CtlRun);
        next_cycle();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        check_eq("t4_stall_cnt", a_stall, 0);
        check_eq("t4_stall_cnt_nb", b_stall, 0);

        // Redirect overrides a simultaneous hazard and bubbles ex
        do_reset();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        next_cycle();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1);
        redirect = 1'b1;
        #1;
        check_eq("t5_flush_ctl", ctl_a(), CtlFlush);
        check_eq("t5_flush_ctl_nb", ctl_b(), CtlFlush);
        next_cycle();
        redirect = 1'b0;
        set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        check_eq("t5_flush_cnt", a_flush, 1);
        check_eq("t5_stall_cnt", a_stall, 0);
        check_eq("t5_ex_bubble", ctl_a(), CtlRun);
        check_eq("t5_ex_bubble_nb", ctl_b(), CtlRun);

        // Continuous self-dependent stream: saturation of the 4-bit counter
        do_reset();
        set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
        repeat (9) next_cycle();
        check_eq("t6_cnt4_mid", c_stall, 6);
        repeat (21) next_cycle();
        check_eq("t6_cnt4_sat", c_stall, 15);
        check_eq("t6_byp_cnt", a_stall, 20);
        check_eq("t6_nobyp_cnt", b_stall, 22);
        repeat (6) next_cycle();
        check_eq("t6_cnt4_hold", c_stall, 15);
        check_eq("t6_byp_cnt2", a_stall, 24);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Stall and flush controller for the 5-stage pipeline without forwarding. It drives the IF/ID and ID/EX pipeline-register control inputs: PC enable, IF/ID enable, IF/ID flush and ID/EX bubble insertion. It keeps a 3-entry destination-register scoreboard that mirrors the instructions in EX, MEM and WB. It also counts stall and flush cycles for performance debug.

Parameters:
WB_BYPASS, 1, 1 = register file writes before it reads in the same cycle, so a WB-stage producer is not a hazard; 0 = WB producer also stalls ID.
CNT_W, 16, width of the saturating stall_cnt and flush_cnt counters.

Ports:
clk_HAZ  in  1  clock; all state updates on the rising edge.
rst_HAZ  in  1  reset, asynchronous, active-high.
valid_ID  in  1  IF/ID holds a real instruction.
rs1_addr_ID  in  5  source register 1 of the ID instruction.
rs1_used_ID  in  1  ID instruction reads rs1.
rs2_addr_ID  in  5  source register 2 of the ID instruction.
rs2_used_ID  in  1  ID instruction reads rs2.
rd_addr_ID  in  5  destination register of the ID instruction.
RegWrite_ID  in  1  ID instruction writes rd.
redirect_EX  in  1  taken branch or jump resolved in EX this cycle.
en_PC  out  1  PC register enable.
en_IFID  out  1  IF/ID register enable.
NOP_IFID  out  1  IF/ID flush (loads a NOP).
NOP_IDEX  out  1  ID/EX bubble insert.
stall_cnt  out  CNT_W  number of stall cycles, saturating.
flush_cnt  out  CNT_W  number of redirect cycles, saturating.

Behaviour:
- State: three slots, ex/mem/wb, each holding {v, rd[4:0]}.
- The ID/EX enable is driven constant 1 by the top level. Stalls are made only by holding PC and IF/ID and asserting NOP_IDEX. This keeps reset effective on that register.
- match(r) = (ex.v & ex.rd==r) | (mem.v & mem.rd==r) | (!WB_BYPASS & wb.v & wb.rd==r).
- hazard = valid_ID & ((rs1_used_ID & rs1_addr_ID!=0 & match(rs1_addr_ID)) | (rs2_used_ID & rs2_addr_ID!=0 & match(rs2_addr_ID))).
- Outputs are combinational from current state and inputs, with zero-cycle latency. Priority order:
  - redirect_EX=1: en_PC=1, en_IFID=1, NOP_IFID=1, NOP_IDEX=1. Any hazard is ignored.
  - else hazard=1: en_PC=0, en_IFID=0, NOP_IFID=0, NOP_IDEX=1.
  - else: en_PC=1, en_IFID=1, NOP_IFID=0, NOP_IDEX=0.
- issue = valid_ID & !hazard & !redirect_EX.
- Each rising edge:
  - ex <= issue ? {RegWrite_ID & rd_addr_ID!=0, rd_addr_ID} : {0,0}.
  - mem <= ex; wb <= mem.
- A redirecting instruction already sits in ex and keeps its slot, so JAL's rd is still tracked.
- Counters:
  - stall_cnt += 1 on cycles with hazard & !redirect_EX.
  - flush_cnt += 1 on cycles with redirect_EX.
  - Both saturate at all-ones and never wrap.
- Worst-case stall for a dependent back-to-back pair: 2 cycles with WB_BYPASS=1, 3 cycles with WB_BYPASS=0.
- rd=0 producers never mark a slot valid. Reads of x0 never stall.
- Reset (async, any time, including mid-stall):
  - All slots become invalid (v=0, rd=0) and both counters become 0.
  - While rst_HAZ=1, outputs still follow the combinational rules on empty state. With redirect_EX=0 this gives en_PC=1, en_IFID=1, NOP_IFID=0, NOP_IDEX=0.
  - The first edge after release samples normally.

Test Plan:
1. Reset in the middle of a 2-cycle stall -> immediately en_PC=1, NOP_IDEX=0, stall_cnt=0, flush_cnt=0; the next instruction issues in the first cycle after release.
2. WB_BYPASS=1: issue addi x5 (RegWrite=1, rd=5); next ID instruction uses rs1=5 -> exactly 2 cycles of en_PC=0, en_IFID=0, NOP_IDEX=1, then issue; stall_cnt=2.
3. WB_BYPASS=0: same sequence -> 3 stall cycles; stall_cnt=3.
4. Producer rd=0 with RegWrite=1, followed by a reader of rs1=0; and a reader with rs2=5 but rs2_used=0 after an x5 producer -> no stall in either case; stall_cnt=0.
5. Hazard present and redirect_EX=1 in the same cycle -> NOP_IFID=1, NOP_IDEX=1, en_PC=1; flush_cnt increments by 1, stall_cnt unchanged; the ex slot loads a bubble on the next edge.
6. CNT_W=4: hold a permanent hazard for 20 cycles -> stall_cnt reaches 15 and stays at 15 with no wrap.
